// File: rtl/vga_map_pkg.sv
// Shared map-display constants and types, also used by the screen-to-world scaler.
package vga_map_pkg;

  localparam int unsigned SCREEN_TO_WORLD_RATIO_COL = 6;
  localparam int unsigned SCREEN_TO_WORLD_RATIO_ROW = 6;
  localparam int unsigned WORLD_COLS                = 128;
  localparam int unsigned WORLD_ROWS                = 128;
  localparam int unsigned MARGIN                    = 128;

  localparam int unsigned SCREEN_W = 12;
  localparam int unsigned WORLD_W  = 7;

  typedef logic [SCREEN_W-1:0] screen_coord_t;
  typedef logic [WORLD_W-1:0]  world_coord_t;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

endpackage

// File: rtl/vga_cell_counter.sv
// Row-major 2-D wrap counter over the sub-cell offsets of one world cell.
module vga_cell_counter #(
  parameter int unsigned RATIO_ROW = 6,
  parameter int unsigned RATIO_COL = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] sub_row,
  output logic [3:0] sub_col,
  output logic       last
);

  localparam logic [3:0] RowMax = 4'(RATIO_ROW - 1);
  localparam logic [3:0] ColMax = 4'(RATIO_COL - 1);

  logic [3:0] row_d, col_d;

  // Next offsets: column advances, wraps to 0 and bumps the row at the end of a line.
  always_comb begin
    row_d = sub_row;
    col_d = sub_col;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (enable) begin
      if (sub_col == ColMax) begin
        col_d = '0;
        row_d = (sub_row == RowMax) ? '0 : sub_row + 4'd1;
      end else begin
        col_d = sub_col + 4'd1;
      end
    end
  end

  // Offset registers; last is registered from the next offsets so it lines up with them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_row <= '0;
      sub_col <= '0;
      last    <= 1'b0;
    end else begin
      sub_row <= row_d;
      sub_col <= col_d;
      last    <= (row_d == RowMax) && (col_d == ColMax);
    end
  end

endmodule

// File: rtl/vga_cell_rasterizer.sv
// World-to-screen rasterizer: one world cell in, every covered screen pixel out in row-major order.
module vga_cell_rasterizer #(
  parameter int unsigned SCREEN_TO_WORLD_RATIO_COL = vga_map_pkg::SCREEN_TO_WORLD_RATIO_COL,
  parameter int unsigned SCREEN_TO_WORLD_RATIO_ROW = vga_map_pkg::SCREEN_TO_WORLD_RATIO_ROW,
  parameter int unsigned WORLD_COLS                = vga_map_pkg::WORLD_COLS,
  parameter int unsigned WORLD_ROWS                = vga_map_pkg::WORLD_ROWS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cell_valid,
  output logic        cell_ready,
  input  logic [6:0]  cell_row,
  input  logic [6:0]  cell_column,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [11:0] pix_row,
  output logic [11:0] pix_column,
  output logic [3:0]  pix_sub_row,
  output logic [3:0]  pix_sub_col,
  output logic        pix_first,
  output logic        pix_last,
  output logic        cell_err
);

  import vga_map_pkg::*;

  localparam logic [3:0] ColMax = 4'(SCREEN_TO_WORLD_RATIO_COL - 1);

  state_t        state_q;
  screen_coord_t base_col_q;
  screen_coord_t base_row_calc, base_col_calc;
  logic          accept, in_range, beat;

  assign cell_ready = (state_q == IDLE);
  assign accept     = cell_valid && cell_ready;
  assign in_range   = (32'(cell_row) < WORLD_ROWS) && (32'(cell_column) < WORLD_COLS);
  assign beat       = pix_valid && pix_ready;

  assign base_row_calc = screen_coord_t'(cell_row) * screen_coord_t'(SCREEN_TO_WORLD_RATIO_ROW);
  assign base_col_calc = screen_coord_t'(cell_column) * screen_coord_t'(SCREEN_TO_WORLD_RATIO_COL)
                         + screen_coord_t'(MARGIN);

  vga_cell_counter #(
    .RATIO_ROW(SCREEN_TO_WORLD_RATIO_ROW),
    .RATIO_COL(SCREEN_TO_WORLD_RATIO_COL)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept && in_range),
    .enable (beat),
    .sub_row(pix_sub_row),
    .sub_col(pix_sub_col),
    .last   (pix_last)
  );

  // Cell FSM; screen coordinates advance incrementally so every pix_* output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pix_valid  <= 1'b0;
      pix_first  <= 1'b0;
      pix_row    <= '0;
      pix_column <= '0;
      base_col_q <= '0;
      cell_err   <= 1'b0;
    end else begin
      cell_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!in_range) begin
              cell_err <= 1'b1;
            end else begin
              state_q    <= EMIT;
              pix_valid  <= 1'b1;
              pix_first  <= 1'b1;
              pix_row    <= base_row_calc;
              pix_column <= base_col_calc;
              base_col_q <= base_col_calc;
            end
          end
        end
        EMIT: begin
          if (beat) begin
            pix_first <= 1'b0;
            if (pix_last) begin
              state_q   <= IDLE;
              pix_valid <= 1'b0;
            end else if (pix_sub_col == ColMax) begin
              pix_column <= base_col_q;
              pix_row    <= pix_row + 12'd1;
            end else begin
              pix_column <= pix_column + 12'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_cell_rasterizer.sv
// Directed bench for vga_cell_rasterizer: default instance plus a WORLD_COLS=100 instance.
module tb_vga_cell_rasterizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cell_valid, pix_ready;
  logic [6:0]  cell_row, cell_column;
  logic        cell_ready, pix_valid, pix_first, pix_last, cell_err;
  logic [11:0] pix_row, pix_column;
  logic [3:0]  pix_sub_row, pix_sub_col;

  logic        c2_valid, p2_ready;
  logic [6:0]  c2_row, c2_column;
  logic        c2_ready, p2_valid, p2_first, p2_last, c2_err;
  logic [11:0] p2_row, p2_column;
  logic [3:0]  p2_sub_row, p2_sub_col;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_cell_rasterizer u_dut (
    .clk        (clk),
    .reset      (reset),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_row   (cell_row),
    .cell_column(cell_column),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_row    (pix_row),
    .pix_column (pix_column),
    .pix_sub_row(pix_sub_row),
    .pix_sub_col(pix_sub_col),
    .pix_first  (pix_first),
    .pix_last   (pix_last),
    .cell_err   (cell_err)
  );

  vga_cell_rasterizer #(
    .WORLD_COLS(100)
  ) u_dut_small (
    .clk        (clk),
    .reset      (reset),
    .cell_valid (c2_valid),
    .cell_ready (c2_ready),
    .cell_row   (c2_row),
    .cell_column(c2_column),
    .pix_valid  (p2_valid),
    .pix_ready  (p2_ready),
    .pix_row    (p2_row),
    .pix_column (p2_column),
    .pix_sub_row(p2_sub_row),
    .pix_sub_col(p2_sub_col),
    .pix_first  (p2_first),
    .pix_last   (p2_last),
    .cell_err   (c2_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Follows one cell already presented to the DUT (accepted at the next rising edge).
  task automatic emit_check(input int r, input int c, input bit stall, input bit keep_valid);
    int idx = 0;
    int cycles = 0;
    int er, ec;
    while (idx < 36 && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (!keep_valid) cell_valid = 1'b0;
      er = r * 6 + idx / 6;
      ec = c * 6 + 128 + idx % 6;
      check("valid", int'(pix_valid), 1);
      check("ready_low", int'(cell_ready), 0);
      check("row", int'(pix_row), er);
      check("col", int'(pix_column), ec);
      check("sub_row", int'(pix_sub_row), idx / 6);
      check("sub_col", int'(pix_sub_col), idx % 6);
      check("first", int'(pix_first), int'(idx == 0));
      check("last", int'(pix_last), int'(idx == 35));
      check("map_row", int'(pix_row) / 6, r);
      check("map_col", (int'(pix_column) - 128) / 6, c);
      pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_ready) idx++;
    end
    check("beat_count", idx, 36);
    @(negedge clk);
    check("idle_valid", int'(pix_valid), 0);
    check("idle_ready", int'(cell_ready), 1);
  endtask

  task automatic send(input int r, input int c);
    @(negedge clk);
    cell_valid  = 1'b1;
    cell_row    = 7'(r);
    cell_column = 7'(c);
    check("send_ready", int'(cell_ready), 1);
  endtask

  initial begin
    reset = 1'b1;
    cell_valid = 1'b0; cell_row = '0; cell_column = '0; pix_ready = 1'b1;
    c2_valid = 1'b0; c2_row = '0; c2_column = '0; p2_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_row", int'(pix_row), 0);
    check("rst_col", int'(pix_column), 0);
    check("rst_sub", int'({pix_sub_row, pix_sub_col}), 0);
    check("rst_flags", int'({pix_first, pix_last, cell_err}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(cell_ready), 1);

    // Corner cells, full-rate and randomly stalled.
    send(0, 0);
    emit_check(0, 0, 1'b0, 1'b0);
    send(127, 127);
    emit_check(127, 127, 1'b0, 1'b0);
    send(10, 20);
    emit_check(10, 20, 1'b1, 1'b0);

    // Second cell held valid during emission is taken only in the IDLE bubble.
    send(0, 0);
    @(negedge clk);
    cell_row = 7'd1;
    cell_column = 7'd1;
    check("b2b_first_row", int'(pix_row), 0);
    check("b2b_first_col", int'(pix_column), 128);
    pix_ready = 1'b0;
    emit_check(0, 0, 1'b0, 1'b1);
    emit_check(1, 1, 1'b0, 1'b0);

    // Reset after the 10th accepted beat.
    send(2, 3);
    pix_ready = 1'b1;
    repeat (10) @(negedge clk);
    cell_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_sub_col", int'(pix_sub_col), 4);
    check("pre_rst_sub_row", int'(pix_sub_row), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", int'(pix_valid), 0);
    check("mid_rst_row", int'(pix_row), 0);
    check("mid_rst_col", int'(pix_column), 0);
    check("mid_rst_sub", int'({pix_sub_row, pix_sub_col}), 0);
    check("mid_rst_flags", int'({pix_first, pix_last}), 0);
    check("mid_rst_ready", int'(cell_ready), 1);
    reset = 1'b0;
    send(3, 4);
    emit_check(3, 4, 1'b0, 1'b0);

    // Out-of-range column on the WORLD_COLS=100 instance.
    @(negedge clk);
    c2_valid = 1'b1; c2_row = 7'd5; c2_column = 7'd100;
    @(negedge clk);
    c2_valid = 1'b0;
    check("err_pulse", int'(c2_err), 1);
    check("err_no_valid", int'(p2_valid), 0);
    check("err_ready", int'(c2_ready), 1);
    @(negedge clk);
    check("err_clear", int'(c2_err), 0);
    check("err_still_idle", int'(p2_valid), 0);
    check("err_ready2", int'(c2_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
